// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush sequencer for an in-order integer pipeline.
// Merges hazard-unit stall/flush requests with an external memory-wait
// stall, propagates that stall as a bubble wave through the back stages,
// and holds a redirect that arrives while stalled until the stall releases.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   ext_stall         external memory/bus not ready
//   haz_stall_f/_d    hazard-unit fetch/decode stall
//   haz_flush         hazard-unit per-stage flush request (bit k = stage k)
//   redirect_valid    taken branch/jump resolved in execute
//   redirect_target   branch/jump target
//   pc_plus4          sequential fetch PC
//   stall             per-stage hold enable
//   flush             per-stage clear (wins over stall in the stage flop)
//   pc_next           next fetch PC
//   redirect_pending  a held redirect is waiting for the stall to release
module pipe_stall_ctrl #(
  parameter int unsigned                NUM_STAGES = 5,
  parameter int unsigned                ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ext_stall,
  input  logic                  haz_stall_f,
  input  logic                  haz_stall_d,
  input  logic [NUM_STAGES-1:0] haz_flush,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  redirect_pending
);

  // dly[j] is ext_stall delayed by j cycles; drives stage j+1
  logic [NUM_STAGES-2:1] dly;
  logic                  pend;
  logic [ADDR_WIDTH-1:0] hold_tgt;
  logic                  rel;

  // Release cycle: a held redirect is steered out as soon as the stall drops
  assign rel = pend & ~ext_stall;

  // Bubble-wave delay line and held-redirect capture
  always_ff @(posedge clk) begin
    if (reset) begin
      dly      <= '0;
      pend     <= 1'b0;
      hold_tgt <= '0;
    end else begin
      dly[1] <= ext_stall;
      for (int j = 2; j <= int'(NUM_STAGES) - 2; j++) begin
        dly[j] <= dly[j-1];
      end
      // Capture takes priority over release; youngest redirect wins
      if (redirect_valid & ext_stall) begin
        pend     <= 1'b1;
        hold_tgt <= redirect_target;
      end else if (rel) begin
        pend <= 1'b0;
      end
    end
  end

  // Per-stage stall/flush and next fetch PC
  always_comb begin
    stall            = '0;
    flush            = '1;
    pc_next          = RESET_PC;
    redirect_pending = 1'b0;
    if (!reset) begin
      stall[0] = ext_stall | haz_stall_f;
      stall[1] = ext_stall | haz_stall_d;
      for (int k = 2; k < int'(NUM_STAGES); k++) begin
        stall[k] = dly[k-1];
      end

      flush    = haz_flush;
      flush[1] = haz_flush[1] | rel;
      // Stage 2 gets the first bubble and also squashes the wrong-path op on release
      flush[2] = haz_flush[2] | rel | dly[1];
      for (int k = 3; k < int'(NUM_STAGES); k++) begin
        flush[k] = haz_flush[k] | dly[k-1];
      end

      redirect_pending = pend;

      // pend without rel means the stall is still active: present the held
      // target, fetch is frozen by stall[0] anyway
      if (rel) begin
        pc_next = hold_tgt;
      end else if (redirect_valid & ~ext_stall) begin
        pc_next = redirect_target;
      end else if (pend) begin
        pc_next = hold_tgt;
      end else begin
        pc_next = pc_plus4;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: a 5-stage and a 7-stage instance share stimulus
// and are checked every cycle against a history-based reference model.
module tb_pipe_stall_ctrl;

  localparam logic [31:0] RPC7 = 32'h8000_0000;

  logic        clk;
  logic        reset;
  logic        ext_stall;
  logic        haz_stall_f;
  logic        haz_stall_d;
  logic [6:0]  haz_flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  logic [4:0]  stall5, flush5;
  logic [31:0] pc5;
  logic        rp5;
  logic [6:0]  stall7, flush7;
  logic [31:0] pc7;
  logic        rp7;

  int checks;
  int errors;

  // Reference state: eh[i] = ext_stall i cycles ago (0 across a reset)
  logic        eh [1:7];
  logic        pend_m;
  logic [31:0] tgt_m;

  pipe_stall_ctrl #(.NUM_STAGES(5), .ADDR_WIDTH(32), .RESET_PC(32'h0)) dut5 (
    .clk(clk), .reset(reset), .ext_stall(ext_stall),
    .haz_stall_f(haz_stall_f), .haz_stall_d(haz_stall_d),
    .haz_flush(haz_flush[4:0]), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .pc_plus4(pc_plus4),
    .stall(stall5), .flush(flush5), .pc_next(pc5), .redirect_pending(rp5)
  );

  pipe_stall_ctrl #(.NUM_STAGES(7), .ADDR_WIDTH(32), .RESET_PC(RPC7)) dut7 (
    .clk(clk), .reset(reset), .ext_stall(ext_stall),
    .haz_stall_f(haz_stall_f), .haz_stall_d(haz_stall_d),
    .haz_flush(haz_flush), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .pc_plus4(pc_plus4),
    .stall(stall7), .flush(flush7), .pc_next(pc7), .redirect_pending(rp7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs of an n-stage instance for the current inputs
  task automatic model(input int n, input logic [31:0] rpc,
                       output logic [7:0] st, output logic [7:0] fl,
                       output logic [31:0] pc, output logic rp);
    logic rel;
    st = '0; fl = '0; pc = rpc; rp = 1'b0;
    if (reset) begin
      for (int k = 0; k < n; k++) fl[k] = 1'b1;
    end else begin
      rel = pend_m & ~ext_stall;
      st[0] = ext_stall | haz_stall_f;
      st[1] = ext_stall | haz_stall_d;
      for (int k = 0; k < n; k++) fl[k] = haz_flush[k];
      for (int k = 2; k < n; k++) begin
        st[k] = eh[k-1];
        fl[k] = fl[k] | eh[k-1];
      end
      fl[1] = fl[1] | rel;
      fl[2] = fl[2] | rel;
      rp = pend_m;
      if (rel)                              pc = tgt_m;
      else if (redirect_valid & ~ext_stall) pc = redirect_target;
      else if (pend_m)                      pc = tgt_m;
      else                                  pc = pc_plus4;
    end
  endtask

  task automatic check_all();
    logic [7:0] st, fl;
    logic [31:0] pc;
    logic rp;
    model(5, 32'h0, st, fl, pc, rp);
    chk("stall5", 32'(stall5), 32'(st[4:0]));
    chk("flush5", 32'(flush5), 32'(fl[4:0]));
    chk("pc5", pc5, pc);
    chk("rp5", 32'(rp5), 32'(rp));
    model(7, RPC7, st, fl, pc, rp);
    chk("stall7", 32'(stall7), 32'(st[6:0]));
    chk("flush7", 32'(flush7), 32'(fl[6:0]));
    chk("pc7", pc7, pc);
    chk("rp7", 32'(rp7), 32'(rp));
  endtask

  task automatic drive(input logic rst, input logic ext, input logic rv,
                       input logic [31:0] tgt, input logic [31:0] pc4);
    @(negedge clk);
    reset           = rst;
    ext_stall       = ext;
    haz_stall_f     = 1'b0;
    haz_stall_d     = 1'b0;
    haz_flush       = '0;
    redirect_valid  = rv;
    redirect_target = tgt;
    pc_plus4        = pc4;
    #1;
  endtask

  // Advance one clock and update the reference model with the applied inputs
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 1; i <= 7; i++) eh[i] = 1'b0;
      pend_m = 1'b0;
      tgt_m  = '0;
    end else begin
      for (int i = 7; i >= 2; i--) eh[i] = eh[i-1];
      eh[1] = ext_stall;
      if (redirect_valid & ext_stall) begin
        pend_m = 1'b1;
        tgt_m  = redirect_target;
      end else if (pend_m & ~ext_stall) begin
        pend_m = 1'b0;
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic ext, input logic rv,
                     input logic [31:0] tgt, input logic [31:0] pc4);
    drive(rst, ext, rv, tgt, pc4);
    check_all();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pend_m = 1'b0;
    tgt_m  = '0;
    for (int i = 1; i <= 7; i++) eh[i] = 1'b0;

    // Reset with ext_stall high
    for (int t = 0; t < 2; t++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h4);
      check_all();
      chk("rst_flush5", 32'(flush5), 32'h1f);
      chk("rst_pc5", pc5, 32'h0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
    check_all();
    chk("post_rst_pc5", pc5, 32'h4);
    chk("post_rst_stall5", 32'(stall5), 32'h0);
    tick();

    // Bubble wave: 3-cycle ext_stall
    for (int t = 0; t < 10; t++) begin
      drive(1'b0, t < 3, 1'b0, 32'h0, 32'h8);
      check_all();
      if (t == 3) chk("wb5_bubble", 32'(stall5[4]), 32'h1);
      if (t == 4) chk("wb7_early", 32'(stall7[6]), 32'h0);
      if (t == 5) chk("wb7_bubble", 32'(stall7[6]), 32'h1);
      if (t == 8) chk("wb7_tail", 32'(flush7[6]), 32'h0);
      tick();
    end

    // Held redirect released after the stall
    for (int t = 0; t < 6; t++) begin
      drive(1'b0, t < 4, t == 1, 32'h100, 32'h40);
      check_all();
      if (t == 2) chk("held_rp", 32'(rp5), 32'h1);
      if (t == 4) begin
        chk("rel_pc", pc5, 32'h100);
        chk("rel_flush12", 32'(flush5[2:1]), 32'h3);
      end
      if (t == 5) chk("rel_cleared", 32'(rp5), 32'h0);
      tick();
    end

    // Unstalled redirect
    drive(1'b0, 1'b0, 1'b1, 32'h2000, 32'h44);
    check_all();
    chk("unstalled_pc", pc5, 32'h2000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h48);
    check_all();
    chk("unstalled_nopend", 32'(rp5), 32'h0);
    tick();

    // Youngest of two held redirects wins
    for (int t = 0; t < 5; t++) begin
      drive(1'b0, t < 4, (t == 0) || (t == 2), (t == 0) ? 32'h100 : 32'h200, 32'h50);
      check_all();
      if (t == 4) chk("overwrite_pc", pc5, 32'h200);
      tick();
    end

    // Reset while a redirect is pending and the wave is in flight
    cyc(1'b0, 1'b1, 1'b1, 32'h100, 32'h60);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h60);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'h60);
    for (int t = 0; t < 6; t++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h64);
      check_all();
      chk("after_rst_pc", pc5, 32'h64);
      chk("after_rst_stall7", 32'(stall7), 32'h0);
      tick();
    end

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      reset           = ($urandom_range(0, 39) == 0);
      ext_stall       = ($urandom_range(0, 9) < 4);
      haz_stall_f     = ($urandom_range(0, 4) == 0);
      haz_stall_d     = ($urandom_range(0, 4) == 0);
      haz_flush       = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h0;
      redirect_valid  = ($urandom_range(0, 3) == 0);
      redirect_target = $urandom;
      pc_plus4        = $urandom;
      #1;
      check_all();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
